// File: rtl/sram_32kx8_sync_if.sv
// sram_32kx8_sync_if
// Control/address bundle between a bus master and the 32K x 8 synchronous SRAM.
// The bidirectional data bus stays a plain inout port on the RAM so that its
// tristate resolution sits on an ordinary net rather than inside the interface.
//
// Signals:
//   addr       word address (ADDR_W bits)
//   ceb        chip enable, active low
//   web        write enable, active low
//   oeb        output enable, active low
//   perr_inj   (SRAM_32KX8_PARITY_EN only) invert stored parity on write
//   parity_err (SRAM_32KX8_PARITY_EN only) registered parity mismatch flag
//
// Modports: master (drives controls), slave (the RAM).
// Optional macro: SRAM_32KX8_PARITY_EN.

interface sram_32kx8_sync_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] addr;
  logic              ceb;
  logic              web;
  logic              oeb;
`ifdef SRAM_32KX8_PARITY_EN
  logic              perr_inj;
  logic              parity_err;

  modport master (output addr, ceb, web, oeb, perr_inj, input parity_err);
  modport slave  (input addr, ceb, web, oeb, perr_inj, output parity_err);
`else
  modport master (output addr, ceb, web, oeb);
  modport slave  (input addr, ceb, web, oeb);
`endif
endinterface

// File: rtl/sram_32kx8_sync.sv
// sram_32kx8_sync
// Single-port 32K x 8 synchronous SRAM with active-low SRAM-style controls and
// a bidirectional byte-wide data bus. Reads have one cycle of latency; the bus
// is driven only while the read controls remain asserted, so a master may
// turn the bus around in the same cycle it drops web or raises ceb/oeb.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset (clears read register/output enable,
//         never touches array contents)
//   bus   sram_32kx8_sync_if.slave: addr, ceb, web, oeb
//         (+ perr_inj, parity_err with SRAM_32KX8_PARITY_EN)
//   data  bidirectional data: sampled on write, driven on read, else high-Z
//
// Optional macro: SRAM_32KX8_PARITY_EN adds one even-parity bit per word.

module sram_32kx8_sync #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_32kx8_sync_if.slave      bus,
  inout  wire  [DATA_W-1:0]     data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              oe_q;
  logic              wr_en;
  logic              rd_en;
  logic              drive_en;

  assign wr_en = ~bus.ceb & ~bus.web;
  assign rd_en = ~bus.ceb &  bus.web;

  // Array has no reset; power-up contents are undefined.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[bus.addr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      if (rd_en) begin
        rdata_q <= mem[bus.addr];
      end
      oe_q <= rd_en & ~bus.oeb;
    end
  end

  // Registered enable plus live control gating: the bus is released as soon
  // as the master starts a write or drops ceb/oeb, with no cycle of overlap.
  assign drive_en = oe_q & rd_en & ~bus.oeb;
  assign data     = drive_en ? rdata_q : {DATA_W{1'bz}};

`ifdef SRAM_32KX8_PARITY_EN
  logic mem_par [DEPTH];
  logic parity_err_q;

  // Stored bit makes data+parity even; perr_inj deliberately corrupts it.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_par[bus.addr] <= (^data) ^ bus.perr_inj;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (rd_en) begin
      parity_err_q <= mem_par[bus.addr] ^ (^mem[bus.addr]);
    end
  end

  assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sram_32kx8_sync.sv
// tb_sram_32kx8_sync
// Directed self-checking bench for sram_32kx8_sync. The data bus carries a
// pull-up on every bit, so a released bus reads 0xFF; no test ever stores
// 0xFF, which makes "reads 0xFF" equivalent to "nothing drives the bus".

module tb_sram_32kx8_sync;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              drv_en;
  logic [DATA_W-1:0] drv_val;
  wire  [DATA_W-1:0] data;

  int total = 0;
  int bad   = 0;

  sram_32kx8_sync_if #(.ADDR_W(ADDR_W)) bus ();

  sram_32kx8_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .data (data)
  );

  assign data = drv_en ? drv_val : {DATA_W{1'bz}};

  for (genvar i = 0; i < DATA_W; i++) begin : g_pu
    pullup pu (data[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ceb = 1'b1;
    bus.web = 1'b1;
    bus.oeb = 1'b1;
    drv_en  = 1'b0;
  endtask

  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.addr = a;
    bus.ceb  = 1'b0;
    bus.web  = 1'b0;
    bus.oeb  = 1'b1;
    drv_val  = d;
    drv_en   = 1'b1;
  endtask

  task automatic drive_read(input logic [ADDR_W-1:0] a);
    bus.addr = a;
    bus.ceb  = 1'b0;
    bus.web  = 1'b1;
    bus.oeb  = 1'b0;
    drv_en   = 1'b0;
  endtask

  task automatic test_reset();
    drive_read(15'h0000);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (data !== 8'hFF) begin
        bad++;
        $display("FAIL reset_hiz_cycle%0d: bus=%h required high-Z (FF)", i, data);
      end
    end
`ifdef SRAM_32KX8_PARITY_EN
    total++;
    if (bus.parity_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_parity_err: got=%b required=0", bus.parity_err);
    end
`endif
    rst = 1'b0;
    #1;
    total++;
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL reset_hiz_after: bus=%h required high-Z (FF)", data);
    end
    idle();
    tick();
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 4; i++) begin
      drive_write(i[ADDR_W-1:0], i[DATA_W-1:0]);
      tick();
    end
    idle();
    tick();
    total++;
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL wr_rd_ceb_idle: bus=%h required high-Z (FF)", data);
    end
    for (int i = 0; i < 4; i++) begin
      drive_read(i[ADDR_W-1:0]);
      tick();
      total++;
      if (data !== i[DATA_W-1:0]) begin
        bad++;
        $display("FAIL wr_rd_addr%0d: got=%h required=%h", i, data, i[DATA_W-1:0]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_disabled();
    drive_write(15'h7FFF, 8'hA5);
    tick();
    drive_write(15'h7FFF, 8'h3C);
    bus.ceb = 1'b1;
    tick();
    drive_read(15'h7FFF);
    tick();
    total++;
    if (data !== 8'hA5) begin
      bad++;
      $display("FAIL disabled_write_blocked: got=%h required=a5", data);
    end
    bus.oeb = 1'b1;
    tick();
    total++;
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL disabled_oeb_hiz: bus=%h required high-Z (FF)", data);
    end
    bus.oeb = 1'b0;
    bus.ceb = 1'b1;
    tick();
    total++;
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL disabled_ceb_hiz: bus=%h required high-Z (FF)", data);
    end
    idle();
    tick();
  endtask

  task automatic test_turnaround();
    drive_read(15'h0001);
    tick();
    total++;
    if (data !== 8'h01) begin
      bad++;
      $display("FAIL turn_read1: got=%h required=01", data);
    end
    drive_write(15'h0002, 8'h55);
    #1;
    total++;
    if (data !== 8'h55) begin
      bad++;
      $display("FAIL turn_release1: bus=%h required=55", data);
    end
    tick();
    drive_read(15'h0002);
    tick();
    total++;
    if (data !== 8'h55) begin
      bad++;
      $display("FAIL turn_readback2: got=%h required=55", data);
    end
    drive_read(15'h0003);
    tick();
    total++;
    if (data !== 8'h03) begin
      bad++;
      $display("FAIL turn_read3: got=%h required=03", data);
    end
    drive_write(15'h0004, 8'h28);
    #1;
    total++;
    if (data !== 8'h28) begin
      bad++;
      $display("FAIL turn_release2: bus=%h required=28", data);
    end
    tick();
    drive_read(15'h0004);
    tick();
    total++;
    if (data !== 8'h28) begin
      bad++;
      $display("FAIL turn_readback4: got=%h required=28", data);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_midread();
    drive_read(15'h0003);
    tick();
    total++;
    if (data !== 8'h03) begin
      bad++;
      $display("FAIL midrd_before: got=%h required=03", data);
    end
    rst = 1'b1;
    tick();
    total++;
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL midrd_reset_hiz: bus=%h required high-Z (FF)", data);
    end
    rst = 1'b0;
    #1;
    total++;
    if (data !== 8'hFF) begin
      bad++;
      $display("FAIL midrd_release_hiz: bus=%h required high-Z (FF)", data);
    end
    tick();
    total++;
    if (data !== 8'h03) begin
      bad++;
      $display("FAIL midrd_after: got=%h required=03", data);
    end
    drive_write(15'h0006, 8'h22);
    tick();
    drive_write(15'h0006, 8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_read(15'h0006);
    tick();
    total++;
    if (data !== 8'h22) begin
      bad++;
      $display("FAIL reset_blocks_write: got=%h required=22", data);
    end
    idle();
    tick();
  endtask

`ifdef SRAM_32KX8_PARITY_EN
  task automatic test_parity();
    drive_write(15'h0005, 8'h0F);
    bus.perr_inj = 1'b1;
    tick();
    bus.perr_inj = 1'b0;
    drive_read(15'h0005);
    tick();
    total++;
    if (data !== 8'h0F) begin
      bad++;
      $display("FAIL parity_data5: got=%h required=0f", data);
    end
    total++;
    if (bus.parity_err !== 1'b1) begin
      bad++;
      $display("FAIL parity_err5: got=%b required=1", bus.parity_err);
    end
    idle();
    tick();
    total++;
    if (bus.parity_err !== 1'b1) begin
      bad++;
      $display("FAIL parity_hold: got=%b required=1", bus.parity_err);
    end
    drive_read(15'h0000);
    tick();
    total++;
    if (bus.parity_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_err0: got=%b required=0", bus.parity_err);
    end
    drive_read(15'h0002);
    tick();
    total++;
    if (bus.parity_err !== 1'b0) begin
      bad++;
      $display("FAIL parity_err2: got=%b required=0", bus.parity_err);
    end
    idle();
    tick();
  endtask
`endif

  initial begin
    rst      = 1'b1;
    bus.addr = '0;
    drv_val  = '0;
    idle();
`ifdef SRAM_32KX8_PARITY_EN
    bus.perr_inj = 1'b0;
`endif
    test_reset();
    test_write_read();
    test_disabled();
    test_turnaround();
    test_reset_midread();
`ifdef SRAM_32KX8_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
